sd_spi_card_responder: RTL and testbench

- Card-side (responder) model of the SD SPI-mode protocol. The host SD controller is the initiator; this block answers it.
- Oversamples SD_clock, SD_cmd (MOSI) and SD_dat3 (CS_n) on clk_50mhz and drives SD_dat (MISO).
- Decodes 48-bit command frames and returns R1/R3/R7 responses.
- Serves CMD17 single-block reads from an external byte memory.
- Used as a loopback target for bring-up and as a synthesizable card emulator.

---
 rtl/sd_spi_pkg.sv | 45 ++++
 rtl/sd_crc16_ccitt.sv | 34 +++
 rtl/sd_spi_card_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared constants, state encoding and the command-frame CRC7 for the SD SPI card responder.
package sd_spi_pkg;

   localparam logic [5:0] CmdGoIdle      = 6'd0;
   localparam logic [5:0] CmdSendIfCond  = 6'd8;
   localparam logic [5:0] CmdSetBlocklen = 6'd16;
   localparam logic [5:0] CmdReadSingle  = 6'd17;
   localparam logic [5:0] AcmdSendOpCond = 6'd41;
   localparam logic [5:0] CmdAppCmd      = 6'd55;
   localparam logic [5:0] CmdReadOcr     = 6'd58;

   localparam int unsigned R1Idle     = 0;
   localparam int unsigned R1Illegal  = 2;
   localparam int unsigned R1CrcErr   = 3;
   localparam int unsigned R1AddrErr  = 5;
   localparam int unsigned R1ParamErr = 6;

   localparam logic [7:0]  DataToken = 8'hFE;
   localparam int unsigned BlockLen  = 512;

   localparam logic [31:0] OcrBase = 32'h80FF_8000;
   localparam logic [31:0] OcrCcs  = 32'h4000_0000;

   typedef enum logic [2:0] {
      StRxWait,
      StRxCmd,
      StRespGap,
      StRespTx,
      StDataGap,
      StDataTx
   } state_e;

   // CRC7 (x^7 + x^3 + 1, init 0) over the first 40 bits of a command frame.
   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 39; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return crc;
   endfunction

endpackage

// File: rtl/sd_crc16_ccitt.sv
// Byte-wise CRC16-CCITT (poly 0x1021, init 0) accumulator, MSB first, with clear and enable.
module sd_crc16_ccitt (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         for (int i = 7; i >= 0; i--) begin
            crc_d = {crc_d[14:0], 1'b0} ^ ((data[i] ^ crc_d[15]) ? 16'h1021 : 16'h0000);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_spi_card_responder.sv
// SD card emulator in SPI mode 0: decodes command frames, answers R1/R3/R7 and serves CMD17
// single-block reads from an external byte memory, all oversampled on clk_50mhz.
module sd_spi_card_responder
   import sd_spi_pkg::*;
#(
   parameter bit          SDHC       = 1'b1,
   parameter int unsigned NCR_BYTES  = 1,
   parameter int unsigned NAC_BYTES  = 2,
   parameter int unsigned INIT_POLLS = 2,
   parameter bit          CHECK_CRC  = 1'b1
) (
   input  logic        clk_50mhz,
   input  logic        reset,
   input  logic        sd_clock,
   input  logic        sd_cmd,
   input  logic        sd_dat3,
   output logic        sd_dat,
   output logic        sd_dat_oe,
   output logic        mem_rd,
   output logic [31:0] blk_addr,
   output logic [8:0]  byte_idx,
   input  logic [7:0]  mem_rdata,
   output logic        cmd_valid,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        idle_state
);

   logic [2:0]  sclk_q;
   logic [1:0]  mosi_q, cs_q;
   logic        sclk_rise, sclk_fall, mosi, cs_n;

   state_e      state_q, state_d;
   logic [46:0] rx_sr_q, rx_sr_d;
   logic [5:0]  rx_cnt_q, rx_cnt_d;
   logic [7:0]  tx_sr_q, tx_sr_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [9:0]  byte_cnt_q, byte_cnt_d;
   logic        last_q, last_d;
   logic [39:0] resp_q, resp_d;
   logic        resp_long_q, resp_long_d;
   logic        read_go_q, read_go_d;
   logic        dat_q, dat_d, oe_q, oe_d;
   logic        mem_rd_q, mem_rd_d, rd_dly_q;
   logic [7:0]  hold_q, hold_d;
   logic [31:0] blk_addr_q, blk_addr_d;
   logic [8:0]  byte_idx_q, byte_idx_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [5:0]  cmd_index_q, cmd_index_d;
   logic [31:0] cmd_arg_q, cmd_arg_d;
   logic        idle_q, idle_d, app_cmd_q, app_cmd_d;
   logic [7:0]  polls_q, polls_d;

   logic [47:0] frame;
   logic [5:0]  f_idx;
   logic [31:0] f_arg;
   logic        frame_ok, f_crc_ok;
   logic [7:0]  r1, ld_byte;
   logic [31:0] trailer, dec_blk;
   logic        dec_long, dec_idle, dec_read;
   logic [7:0]  dec_polls;
   logic        crc_clr, crc_en;
   logic [15:0] crc;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign mosi      = mosi_q[1];
   assign cs_n      = cs_q[1];

   assign frame    = {rx_sr_q, mosi};
   assign f_idx    = frame[45:40];
   assign f_arg    = frame[39:8];
   assign frame_ok = frame[46] & frame[0];
   assign f_crc_ok = !CHECK_CRC || (crc7(frame[47:8]) == frame[7:1]);

   // Command decode: response bytes and card-flag updates for the frame completing now.
   always_comb begin
      r1        = '0;
      trailer   = '0;
      dec_long  = 1'b0;
      dec_idle  = idle_q;
      dec_polls = polls_q;
      dec_read  = 1'b0;
      dec_blk   = blk_addr_q;
      case (f_idx)
         CmdGoIdle: begin
            if (!f_crc_ok) begin
               r1[R1CrcErr] = 1'b1;
            end else begin
               dec_idle  = 1'b1;
               dec_polls = '0;
            end
         end
         CmdSendIfCond: begin
            if (!f_crc_ok) begin
               r1[R1CrcErr] = 1'b1;
            end else begin
               dec_long = 1'b1;
               trailer  = {16'h0000, 4'h0, f_arg[11:8], f_arg[7:0]};
            end
         end
         CmdAppCmd: ;
         AcmdSendOpCond: begin
            if (app_cmd_q) begin
               if (polls_q != 8'hFF) dec_polls = polls_q + 8'd1;
               if ({24'd0, dec_polls} >= INIT_POLLS) dec_idle = 1'b0;
            end else begin
               r1[R1Illegal] = 1'b1;
            end
         end
         CmdReadOcr: begin
            dec_long = 1'b1;
            trailer  = (SDHC && !idle_q) ? (OcrBase | OcrCcs) : OcrBase;
         end
         CmdSetBlocklen: begin
            if (f_arg != BlockLen) r1[R1ParamErr] = 1'b1;
         end
         CmdReadSingle: begin
            if (idle_q) begin
               r1[R1Illegal] = 1'b1;
            end else if (!SDHC && f_arg[8:0] != 9'd0) begin
               r1[R1AddrErr] = 1'b1;
            end else begin
               dec_read = 1'b1;
               dec_blk  = SDHC ? f_arg : {9'd0, f_arg[31:9]};
            end
         end
         default: r1[R1Illegal] = 1'b1;
      endcase
      r1[R1Idle] = dec_idle;
   end

   always_comb begin
      state_d     = state_q;
      rx_sr_d     = rx_sr_q;
      rx_cnt_d    = rx_cnt_q;
      tx_sr_d     = tx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      last_d      = last_q;
      resp_d      = resp_q;
      resp_long_d = resp_long_q;
      read_go_d   = read_go_q;
      dat_d       = dat_q;
      oe_d        = oe_q;
      mem_rd_d    = 1'b0;
      hold_d      = rd_dly_q ? mem_rdata : hold_q;
      blk_addr_d  = blk_addr_q;
      byte_idx_d  = byte_idx_q;
      cmd_valid_d = 1'b0;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;
      idle_d      = idle_q;
      app_cmd_d   = app_cmd_q;
      polls_d     = polls_q;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
      ld_byte     = 8'hFF;

      if (cs_n) begin
         state_d   = StRxWait;
         oe_d      = 1'b0;
         dat_d     = 1'b1;
         rx_cnt_d  = '0;
         bit_cnt_d = '0;
         last_d    = 1'b0;
         read_go_d = 1'b0;
      end else begin
         case (state_q)
            StRxWait: begin
               if (sclk_rise && !mosi) begin
                  rx_sr_d  = {rx_sr_q[45:0], mosi};
                  rx_cnt_d = 6'd1;
                  state_d  = StRxCmd;
               end
            end
            StRxCmd: begin
               if (sclk_rise) begin
                  rx_sr_d  = {rx_sr_q[45:0], mosi};
                  rx_cnt_d = rx_cnt_q + 6'd1;
                  if (rx_cnt_q == 6'd47) begin
                     rx_cnt_d = '0;
                     state_d  = StRxWait;
                     if (frame_ok) begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = f_idx;
                        cmd_arg_d   = f_arg;
                        idle_d      = dec_idle;
                        app_cmd_d   = (f_idx == CmdAppCmd);
                        polls_d     = dec_polls;
                        read_go_d   = dec_read;
                        blk_addr_d  = dec_blk;
                        resp_d      = {r1, trailer};
                        resp_long_d = dec_long;
                        byte_cnt_d  = '0;
                        bit_cnt_d   = '0;
                        last_d      = 1'b0;
                        state_d     = StRespGap;
                     end
                  end
               end
            end
            default: begin
               // Transmit states: bytes are loaded at the falling edge that drives their MSB.
               if (sclk_fall) begin
                  if (bit_cnt_q != 3'd0) begin
                     dat_d     = tx_sr_q[7];
                     tx_sr_d   = {tx_sr_q[6:0], 1'b1};
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end else if (last_q) begin
                     state_d = StRxWait;
                     oe_d    = 1'b0;
                     dat_d   = 1'b1;
                     last_d  = 1'b0;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 10'd1;
                     case (state_q)
                        StRespGap: begin
                           if (byte_cnt_q == 10'(NCR_BYTES - 1)) begin
                              state_d    = StRespTx;
                              byte_cnt_d = '0;
                           end
                        end
                        StRespTx: begin
                           ld_byte = resp_q[39:32];
                           resp_d  = {resp_q[31:0], 8'hFF};
                           if (byte_cnt_q == (resp_long_q ? 10'd4 : 10'd0)) begin
                              byte_cnt_d = '0;
                              if (read_go_q) state_d = StDataGap;
                              else           last_d  = 1'b1;
                           end
                        end
                        StDataGap: begin
                           if (byte_cnt_q == 10'(NAC_BYTES - 1)) begin
                              state_d    = StDataTx;
                              byte_cnt_d = '0;
                           end
                        end
                        StDataTx: begin
                           if (byte_cnt_q == 10'd0) begin
                              ld_byte    = DataToken;
                              mem_rd_d   = 1'b1;
                              byte_idx_d = '0;
                              crc_clr    = 1'b1;
                           end else if (byte_cnt_q <= 10'(BlockLen)) begin
                              // Prefetch the next byte while this one shifts out.
                              ld_byte    = hold_q;
                              crc_en     = 1'b1;
                              byte_idx_d = byte_idx_q + 9'd1;
                              mem_rd_d   = (byte_cnt_q != 10'(BlockLen));
                           end else if (byte_cnt_q == 10'(BlockLen + 1)) begin
                              ld_byte = crc[15:8];
                           end else begin
                              ld_byte   = crc[7:0];
                              last_d    = 1'b1;
                              read_go_d = 1'b0;
                           end
                        end
                        default: ;
                     endcase
                     oe_d      = 1'b1;
                     dat_d     = ld_byte[7];
                     tx_sr_d   = {ld_byte[6:0], 1'b1};
                     bit_cnt_d = 3'd1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_50mhz or posedge reset) begin
      if (reset) begin
         sclk_q      <= '0;
         mosi_q      <= '1;
         cs_q        <= '1;
         state_q     <= StRxWait;
         rx_sr_q     <= '0;
         rx_cnt_q    <= '0;
         tx_sr_q     <= 8'hFF;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         last_q      <= 1'b0;
         resp_q      <= '1;
         resp_long_q <= 1'b0;
         read_go_q   <= 1'b0;
         dat_q       <= 1'b1;
         oe_q        <= 1'b0;
         mem_rd_q    <= 1'b0;
         rd_dly_q    <= 1'b0;
         hold_q      <= '0;
         blk_addr_q  <= '0;
         byte_idx_q  <= '0;
         cmd_valid_q <= 1'b0;
         cmd_index_q <= '0;
         cmd_arg_q   <= '0;
         idle_q      <= 1'b1;
         app_cmd_q   <= 1'b0;
         polls_q     <= '0;
      end else begin
         sclk_q      <= {sclk_q[1:0], sd_clock};
         mosi_q      <= {mosi_q[0], sd_cmd};
         cs_q        <= {cs_q[0], sd_dat3};
         state_q     <= state_d;
         rx_sr_q     <= rx_sr_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_sr_q     <= tx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         last_q      <= last_d;
         resp_q      <= resp_d;
         resp_long_q <= resp_long_d;
         read_go_q   <= read_go_d;
         dat_q       <= dat_d;
         oe_q        <= oe_d;
         mem_rd_q    <= mem_rd_d;
         rd_dly_q    <= mem_rd_q;
         hold_q      <= hold_d;
         blk_addr_q  <= blk_addr_d;
         byte_idx_q  <= byte_idx_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
         idle_q      <= idle_d;
         app_cmd_q   <= app_cmd_d;
         polls_q     <= polls_d;
      end
   end

   sd_crc16_ccitt u_crc (
      .clk   (clk_50mhz),
      .reset (reset),
      .clr   (crc_clr),
      .en    (crc_en),
      .data  (ld_byte),
      .crc   (crc)
   );

   assign sd_dat     = dat_q;
   assign sd_dat_oe  = oe_q;
   assign mem_rd     = mem_rd_q;
   assign blk_addr   = blk_addr_q;
   assign byte_idx   = byte_idx_q;
   assign cmd_valid  = cmd_valid_q;
   assign cmd_index  = cmd_index_q;
   assign cmd_arg    = cmd_arg_q;
   assign idle_state = idle_q;

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Directed bench: an SPI-mode host drives one block-addressed card and one byte-addressed card.
module tb_sd_spi_card_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sd_clock = 1'b0;
   logic        sd_cmd = 1'b1;
   logic        cs_a = 1'b1;
   logic        cs_b = 1'b1;
   logic        sel_b = 1'b0;
   logic [7:0]  rdata_a = 8'h00;
   logic [7:0]  rdata_b = 8'h00;

   logic        dat_a, oe_a, rd_a, vld_a, idle_a;
   logic [31:0] blk_a, arg_a;
   logic [8:0]  bidx_a;
   logic [5:0]  idx_a;
   logic        dat_b, oe_b, rd_b, vld_b, idle_b;
   logic [31:0] blk_b, arg_b;
   logic [8:0]  bidx_b;
   logic [5:0]  idx_b;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_rd    = 0;
   logic [5:0] last_idx = '0;

   sd_spi_card_responder dut (
      .clk_50mhz (clk), .reset (reset), .sd_clock (sd_clock), .sd_cmd (sd_cmd),
      .sd_dat3 (cs_a), .sd_dat (dat_a), .sd_dat_oe (oe_a), .mem_rd (rd_a),
      .blk_addr (blk_a), .byte_idx (bidx_a), .mem_rdata (rdata_a), .cmd_valid (vld_a),
      .cmd_index (idx_a), .cmd_arg (arg_a), .idle_state (idle_a)
   );

   sd_spi_card_responder #(.SDHC (1'b0)) dut0 (
      .clk_50mhz (clk), .reset (reset), .sd_clock (sd_clock), .sd_cmd (sd_cmd),
      .sd_dat3 (cs_b), .sd_dat (dat_b), .sd_dat_oe (oe_b), .mem_rd (rd_b),
      .blk_addr (blk_b), .byte_idx (bidx_b), .mem_rdata (rdata_b), .cmd_valid (vld_b),
      .cmd_index (idx_b), .cmd_arg (arg_b), .idle_state (idle_b)
   );

   always #10 clk = ~clk;

   // Memory returns the low byte of the requested offset, one clock after the strobe.
   always @(posedge clk) if (rd_a) rdata_a <= bidx_a[7:0];

   always @(negedge clk) begin
      if (vld_a) begin
         n_valid  = n_valid + 1;
         last_idx = idx_a;
      end
      if (rd_a) n_rd = n_rd + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         sd_cmd = tx[i];
         #80 sd_clock = 1'b1;
         rx[i] = sel_b ? dat_b : dat_a;
         #80 sd_clock = 1'b0;
      end
   endtask

   task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb);
      logic [47:0] f;
      logic [7:0]  d;
      f = {2'b01, idx, arg, crcb};
      for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], d);
   endtask

   task automatic read_n(input int n, output logic [47:0] obs);
      logic [7:0] b;
      obs = '0;
      for (int i = 0; i < n; i++) begin
         xfer(8'hFF, b);
         obs = {obs[39:0], b};
      end
   endtask

   task automatic cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                      input logic [7:0] crcb, input int n, input logic [47:0] exp);
      logic [47:0] obs;
      send(idx, arg, crcb);
      read_n(n + 1, obs);
      check(tag, 64'(obs), 64'(exp));
   endtask

   function automatic logic [15:0] crc16_model();
      logic [15:0] c;
      logic [7:0]  byt;
      logic        b;
      c = '0;
      for (int i = 0; i < 4096; i++) begin
         byt = 8'(i / 8);
         b   = byt[7 - (i % 8)];
         c   = {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   initial begin
      logic [47:0] obs;
      logic [7:0]  b;
      int          bad;

      repeat (3) @(negedge clk);
      check("reset ctl", 64'({dat_a, oe_a, rd_a, vld_a, idle_a}), 64'(5'b10001));
      check("reset regs", 64'({idx_a, arg_a, bidx_a}), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      cs_a = 1'b0;
      #160;

      cmd("cmd0", 6'd0, 32'h0, 8'h95, 1, 48'hFF_01);
      check("cmd0 valid count", 64'(n_valid), 64'd1);
      check("cmd0 index", 64'(last_idx), 64'd0);
      cmd("cmd8", 6'd8, 32'h0000_01AA, 8'h87, 5, 48'hFF_01_00_00_01_AA);
      check("cmd8 index", 64'(idx_a), 64'd8);
      cmd("cmd5 illegal", 6'd5, 32'h0, 8'hFF, 1, 48'hFF_05);
      cmd("cmd0 bad crc", 6'd0, 32'h0, 8'h01, 1, 48'hFF_09);
      send(6'd0, 32'h0, 8'h00);
      read_n(2, obs);
      check("bad end bit silent", 64'(obs), 64'hFFFF);
      check("bad end bit no valid", 64'(n_valid), 64'd4);

      cmd("cmd55 a", 6'd55, 32'h0, 8'hFF, 1, 48'hFF_01);
      cmd("acmd41 a", 6'd41, 32'h4000_0000, 8'hFF, 1, 48'hFF_01);
      check("idle after 1 poll", 64'(idle_a), 64'd1);
      cmd("cmd55 b", 6'd55, 32'h0, 8'hFF, 1, 48'hFF_01);
      cmd("acmd41 b", 6'd41, 32'h4000_0000, 8'hFF, 1, 48'hFF_00);
      check("idle after 2 polls", 64'(idle_a), 64'd0);
      cmd("cmd41 no app", 6'd41, 32'h4000_0000, 8'hFF, 1, 48'hFF_04);
      cmd("cmd58 sdhc", 6'd58, 32'h0, 8'hFF, 5, 48'hFF_00_C0_FF_80_00);

      n_rd = 0;
      cmd("cmd17 r1", 6'd17, 32'h0000_0005, 8'hFF, 1, 48'hFF_00);
      read_n(3, obs);
      check("nac + token", 64'(obs), 64'hFF_FF_FE);
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         xfer(8'hFF, b);
         if (b !== 8'(i)) bad++;
      end
      check("data bytes bad", 64'(bad), 64'd0);
      read_n(2, obs);
      check("crc16", 64'(obs), 64'(crc16_model()));
      check("blk_addr", 64'(blk_a), 64'd5);
      check("mem_rd count", 64'(n_rd), 64'd512);
      check("byte_idx wrap", 64'(bidx_a), 64'd0);
      check("cmd_arg", 64'(arg_a), 64'd5);
      read_n(1, obs);
      check("idle after block", 64'({obs[7:0], 7'd0, oe_a}), 64'hFF00);

      cmd("cmd17 again", 6'd17, 32'h0000_0005, 8'hFF, 1, 48'hFF_00);
      read_n(3, obs);
      for (int i = 0; i < 100; i++) xfer(8'hFF, b);
      check("oe during read", 64'(oe_a), 64'd1);
      cs_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("cs abort", 64'({oe_a, dat_a, rd_a}), 64'(3'b010));
      @(negedge clk);
      #160;
      cs_a = 1'b0;
      #160;
      cmd("cmd58 after abort", 6'd58, 32'h0, 8'hFF, 5, 48'hFF_00_C0_FF_80_00);

      cs_a  = 1'b1;
      sel_b = 1'b1;
      cs_b  = 1'b0;
      #160;
      cmd("b cmd0", 6'd0, 32'h0, 8'h95, 1, 48'hFF_01);
      cmd("b cmd58 idle", 6'd58, 32'h0, 8'hFF, 5, 48'hFF_01_80_FF_80_00);
      cmd("b cmd55 a", 6'd55, 32'h0, 8'hFF, 1, 48'hFF_01);
      cmd("b acmd41 a", 6'd41, 32'h4000_0000, 8'hFF, 1, 48'hFF_01);
      cmd("b cmd55 b", 6'd55, 32'h0, 8'hFF, 1, 48'hFF_01);
      cmd("b acmd41 b", 6'd41, 32'h4000_0000, 8'hFF, 1, 48'hFF_00);
      cmd("b cmd58 ready", 6'd58, 32'h0, 8'hFF, 5, 48'hFF_00_80_FF_80_00);
      cmd("b cmd17 misaligned", 6'd17, 32'h0000_0201, 8'hFF, 1, 48'hFF_20);
      read_n(4, obs);
      check("b no token", 64'({obs[31:0], 7'd0, oe_b}), 64'hFFFF_FFFF_00);
      cmd("b cmd16 bad len", 6'd16, 32'h0000_0100, 8'hFF, 1, 48'hFF_40);
      cmd("b cmd16 ok", 6'd16, 32'h0000_0200, 8'hFF, 1, 48'hFF_00);

      cs_b  = 1'b1;
      sel_b = 1'b0;
      cs_a  = 1'b0;
      #160;
      send(6'd58, 32'h0, 8'hFF);
      read_n(2, obs);
      check("oe mid-response", 64'(oe_a), 64'd1);
      reset = 1'b1;
      #1;
      check("async reset ctl", 64'({dat_a, oe_a, rd_a, vld_a, idle_a}), 64'(5'b10001));
      check("async reset regs", 64'({idx_a, arg_a, blk_a, bidx_a}), 64'd0);
      #100 reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
